// File: rtl/utils.sv
// Shared types and defaults for the CDB issue scheduler slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: unit-id enum, default latency/horizon constants, the rdy/rd
// control bundle, and the slot-index helper used by the shift register.
package utils;

  typedef enum logic [1:0] {
    INT  = 2'd0,
    MEM  = 2'd1,
    MULT = 2'd2,
    DIV  = 2'd3
  } unit_id_t;

  localparam int NUM_UNITS      = 4;
  localparam int DEF_INT_LAT    = 1;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_MULT_LAT   = 4;
  localparam int DEF_DIV_LAT    = 6;
  localparam int DEF_SLOTS      = 8;
  localparam int DEF_STARVE_LIM = 4;

  // Per-unit station handshake, bit index = unit_id_t.
  typedef struct packed {
    logic [NUM_UNITS-1:0] rdy;
    logic [NUM_UNITS-1:0] rd;
  } cdb_sched_ctrl_t;

  // Slot written at the clock edge of a grant for a unit of latency lat.
  // Latency-1 units bypass the vector, so their value is never used.
  function automatic int ins_pos(input int lat);
    return (lat >= 2) ? lat - 2 : 0;
  endfunction

endpackage

// File: rtl/cdb_slot_shifter.sv
// CDB reservation vector and owner array, shifting one slot per cycle.
// Latency: a grant of latency L reaches cur_vld/cur_owner exactly L cycles later.
// Backpressure: none; caller only inserts into slots reported free.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   ins             units granted this cycle (bit index = unit_id_t)
//   slot_busy       per unit: the CDB cycle that unit would hit is already taken
//   cur_vld         the CDB is driven this cycle
//   cur_owner       unit that owns the CDB this cycle
module cdb_slot_shifter
  import utils::*;
#(
  parameter int SLOTS    = DEF_SLOTS,
  parameter int INT_LAT  = DEF_INT_LAT,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_UNITS-1:0] ins,
  output logic [NUM_UNITS-1:0] slot_busy,
  output logic                 cur_vld,
  output unit_id_t             cur_owner
);

  localparam int LAT [NUM_UNITS] = '{INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT};

  // res[k] set: CDB cycle (now + 1 + k) is reserved by own[k].
  logic [SLOTS-1:0]      res, res_nxt;
  logic [SLOTS-1:0][1:0] own, own_nxt;
  logic                  cur_q, cur_q_nxt;
  logic [1:0]            cur_id, cur_id_nxt;

  always_comb begin
    res_nxt    = res >> 1;
    own_nxt    = '0;
    for (int k = 0; k < SLOTS - 1; k++) begin
      own_nxt[k] = own[k+1];
    end
    cur_q_nxt  = res[0];
    cur_id_nxt = own[0];
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (ins[u]) begin
        if (LAT[u] == 1) begin
          // Lands next cycle: straight into the current-owner register.
          cur_q_nxt  = 1'b1;
          cur_id_nxt = u[1:0];
        end else begin
          res_nxt[ins_pos(LAT[u])] = 1'b1;
          own_nxt[ins_pos(LAT[u])] = u[1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res    <= '0;
      own    <= '0;
      cur_q  <= 1'b0;
      cur_id <= '0;
    end else begin
      res    <= res_nxt;
      own    <= own_nxt;
      cur_q  <= cur_q_nxt;
      cur_id <= cur_id_nxt;
    end
  end

  always_comb begin
    slot_busy = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      slot_busy[u] = res[LAT[u]-1];
    end
  end

  assign cur_vld   = cur_q;
  assign cur_owner = unit_id_t'(cur_id);

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Grants issue to int/mem/mult/div stations only when their CDB write-back cycle is free.
// Latency: grants are combinational (same cycle as rdy); cdb_sel for a grant appears L cycles later.
// Backpressure: a blocked station keeps rdy high and is retried every cycle, nothing is dropped.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   <unit>_issue_rdy         station holds an issuable entry
//   <unit>_rd                issue grant / station pop, sampled at the clock edge
//   cdb_sel[3:0]             one-hot CDB source: [0] int, [1] mem, [2] mult, [3] div
//   div_busy                 non-pipelined divider occupied
// Build option: CDB_STARVE_GUARD_EN compiles in per-unit wait counters and the
// starvation guard that holds back longer-latency units behind a starving one.
module cdb_issue_scheduler
  import utils::*;
#(
  parameter int INT_LAT    = DEF_INT_LAT,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int MULT_LAT   = DEF_MULT_LAT,
  parameter int DIV_LAT    = DEF_DIV_LAT,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       int_issue_rdy,
  input  logic       mem_issue_rdy,
  input  logic       mult_issue_rdy,
  input  logic       div_issue_rdy,
  output logic       int_rd,
  output logic       mem_rd,
  output logic       mult_rd,
  output logic       div_rd,
  output logic [3:0] cdb_sel,
  output logic       div_busy
);

  localparam int LAT [NUM_UNITS] = '{INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT};
  localparam int DCW = $clog2(DIV_LAT + 1);

  // Distinct latencies are what make simultaneous grants collision-free.
  localparam bit LAT_RANGE_OK =
      (INT_LAT  >= 1) && (INT_LAT  <= SLOTS) && (MEM_LAT >= 1) && (MEM_LAT <= SLOTS) &&
      (MULT_LAT >= 1) && (MULT_LAT <= SLOTS) && (DIV_LAT >= 1) && (DIV_LAT <= SLOTS);
  localparam bit LAT_DISTINCT =
      (INT_LAT != MEM_LAT) && (INT_LAT != MULT_LAT) && (INT_LAT != DIV_LAT) &&
      (MEM_LAT != MULT_LAT) && (MEM_LAT != DIV_LAT) && (MULT_LAT != DIV_LAT);

  if (!(LAT_RANGE_OK && LAT_DISTINCT && (STARVE_LIM >= 1))) begin : g_cfg_err
    $error("cdb_issue_scheduler: latencies must be distinct and in 1..SLOTS, STARVE_LIM >= 1");
  end

  cdb_sched_ctrl_t      ctrl;
  logic [NUM_UNITS-1:0] slot_busy;
  logic [NUM_UNITS-1:0] supp;
  logic                 cur_vld;
  unit_id_t             cur_owner;
  logic [DCW-1:0]       div_cnt;

  // Grants are held off while reset is asserted so a station with rdy high
  // cannot pop an entry that the cleared reservation state never accounts for.
  always_comb begin
    ctrl.rdy = {div_issue_rdy, mult_issue_rdy, mem_issue_rdy, int_issue_rdy};
    ctrl.rd  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      ctrl.rd[u] = i_rst_n & ctrl.rdy[u] & ~slot_busy[u] & ~supp[u];
    end
    if (div_cnt != '0) begin
      ctrl.rd[DIV] = 1'b0;
    end
  end

  assign int_rd  = ctrl.rd[INT];
  assign mem_rd  = ctrl.rd[MEM];
  assign mult_rd = ctrl.rd[MULT];
  assign div_rd  = ctrl.rd[DIV];

  cdb_slot_shifter #(
    .SLOTS    (SLOTS),
    .INT_LAT  (INT_LAT),
    .MEM_LAT  (MEM_LAT),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_slot_shifter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .ins       (ctrl.rd),
    .slot_busy (slot_busy),
    .cur_vld   (cur_vld),
    .cur_owner (cur_owner)
  );

  // cdb_sel decodes registered state only, so it carries no path from rdy.
  always_comb begin
    cdb_sel = '0;
    if (cur_vld) begin
      cdb_sel[cur_owner] = 1'b1;
    end
  end

  // Divider occupancy: re-issue allowed once the count is back to zero,
  // i.e. DIV_LAT cycles after the previous grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
    end else if (ctrl.rd[DIV]) begin
      div_cnt <= DCW'(DIV_LAT - 1);
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  assign div_busy = (div_cnt != '0);

`ifdef CDB_STARVE_GUARD_EN
  localparam int WCW = $clog2(STARVE_LIM + 1);

  logic [WCW-1:0]       wait_cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0] starved;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        wait_cnt[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (!ctrl.rdy[u] || ctrl.rd[u]) begin
          wait_cnt[u] <= '0;
        end else if (!starved[u]) begin
          wait_cnt[u] <= wait_cnt[u] + 1'b1;
        end
      end
    end
  end

  // Suppressing every unit slower than some starving unit is the same as
  // suppressing everything slower than the fastest starving unit. Once the
  // slower units stop inserting, the starving unit's target slot drains
  // within SLOTS cycles.
  always_comb begin
    supp = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      starved[u] = (wait_cnt[u] == WCW'(STARVE_LIM));
    end
    for (int x = 0; x < NUM_UNITS; x++) begin
      for (int y = 0; y < NUM_UNITS; y++) begin
        if (starved[y] && (LAT[y] < LAT[x])) begin
          supp[x] = 1'b1;
        end
      end
    end
  end
`else
  assign supp = '0;
`endif

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Directed-vector bench for cdb_issue_scheduler with default parameters.
// Each vector is one clock cycle: drive rst_n/rdy just after the rising edge,
// then compare rd, cdb_sel and div_busy at the falling edge.
module tb_cdb_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rdy;          // [0] int, [1] mem, [2] mult, [3] div
  logic       int_rd, mem_rd, mult_rd, div_rd;
  logic [3:0] cdb_sel;
  logic       div_busy;

  int n_vec  = 0;
  int n_err  = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  cdb_issue_scheduler dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .int_issue_rdy  (rdy[0]),
    .mem_issue_rdy  (rdy[1]),
    .mult_issue_rdy (rdy[2]),
    .div_issue_rdy  (rdy[3]),
    .int_rd         (int_rd),
    .mem_rd         (mem_rd),
    .mult_rd        (mult_rd),
    .div_rd         (div_rd),
    .cdb_sel        (cdb_sel),
    .div_busy       (div_busy)
  );

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One cycle: rst level, rdy vector, then expected rd vector, cdb_sel, div_busy.
  task automatic vec(input logic rst, input logic [3:0] r, input logic [3:0] erd,
                     input logic [3:0] esel, input logic ebusy);
    rst_n = rst;
    rdy   = r;
    @(negedge clk);
    check_val($sformatf("c%0d rd", cyc_no), {div_rd, mult_rd, mem_rd, int_rd}, erd);
    check_val($sformatf("c%0d cdb_sel", cyc_no), cdb_sel, esel);
    check_val($sformatf("c%0d div_busy", cyc_no), {3'b000, div_busy}, {3'b000, ebusy});
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 4'b0000;
    @(posedge clk);
    #1;

    // Reset held with every station ready: nothing may be granted.
    vec(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    vec(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    // Release with all ready: distinct latencies let all four issue at once.
    vec(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1);   // int, L=1
    vec(1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b1);   // mem, L=2
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b1);   // mult, L=4
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    vec(1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0);   // div, L=6
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Single int pulse.
    vec(1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // int, mem, mult together.
    vec(1'b1, 4'b0111, 4'b0111, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // mult at t, int ready at t+3 collides with mult's slot, issues at t+4.
    vec(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vec(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    vec(1'b1, 4'b0001, 4'b0001, 4'b0100, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // div held ready: grants at t and t+6, busy in between.
    vec(1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) vec(1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1);
    vec(1'b1, 4'b1000, 4'b1000, 4'b1000, 1'b0);
    for (int i = 0; i < 5; i++) vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    vec(1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-flight: pending mult/div results and divider occupancy vanish.
    vec(1'b1, 4'b1100, 4'b1100, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    vec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // mult continuously ready from t, int continuously ready from t+3.
    for (int i = 0; i < 3; i++) vec(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    vec(1'b1, 4'b0101, 4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) vec(1'b1, 4'b0101, 4'b0100, 4'b0100, 1'b0);
`ifdef CDB_STARVE_GUARD_EN
    // int starving from t+7: mult held back until int gets its slot at t+10.
    for (int i = 0; i < 3; i++) vec(1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b0);
    vec(1'b1, 4'b0101, 4'b0001, 4'b0100, 1'b0);
    vec(1'b1, 4'b0101, 4'b0101, 4'b0001, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`else
    // No guard: mult keeps the int slot occupied, int never issues.
    for (int i = 0; i < 5; i++) vec(1'b1, 4'b0101, 4'b0100, 4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) vec(1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
